// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button, digit and counter-cell control bundle for the stopwatch sequencer
interface stopwatch_ctrl_if;
  logic btn_start;
  logic btn_lap;
  logic btn_clear;
  logic [15:0] digits;
  logic [3:0] cnt_enable;
  logic cnt_reset;
  logic hold;
  logic running;
  logic overflow;
  modport master (
    output btn_start, btn_lap, btn_clear, digits,
    input  cnt_enable, cnt_reset, hold, running, overflow
  );
  modport slave (
    input  btn_start, btn_lap, btn_clear, digits,
    output cnt_enable, cnt_reset, hold, running, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: tick prescaler, BCD carry chain and start/stop/lap/clear sequencing for a 00.00-99.99 stopwatch
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int PRE_W = 17
) (
  input logic clock,
  input logic reset,
  stopwatch_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN, LAP, STOPPED, DONE} state_t;
  state_t state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0] prev_q, prev_d;
  logic cnt_reset_q, cnt_reset_d;
  logic e_clear, e_start, e_lap, act, tick, term, clr_acc;
  logic [3:0] nine;
  assign prev_d = {bus.btn_clear, bus.btn_start, bus.btn_lap};
  assign {e_clear, e_start, e_lap} = prev_d & ~prev_q;
  assign act = (state_q == RUN) || (state_q == LAP);
  assign tick = act && (pre_q == PRE_W'(TICK_DIV - 1));
  assign nine = {bus.digits[15:12] == 4'd9, bus.digits[11:8] == 4'd9,
                 bus.digits[7:4] == 4'd9, bus.digits[3:0] == 4'd9};
  // at 99.99 the tick is swallowed so the counters saturate instead of wrapping
  assign term = tick && (&nine);
  always_comb begin
    state_d = state_q;
    clr_acc = 1'b0;
    case (state_q)
      IDLE:    if (e_clear) clr_acc = 1'b1; else if (e_start) state_d = RUN;
      RUN:     if (term) state_d = DONE; else if (e_start) state_d = STOPPED; else if (e_lap) state_d = LAP;
      LAP:     if (term) state_d = DONE; else if (e_start) state_d = STOPPED; else if (e_lap) state_d = RUN;
      STOPPED: if (e_clear) clr_acc = 1'b1; else if (e_start) state_d = RUN;
      DONE:    if (e_clear) clr_acc = 1'b1;
      default: state_d = IDLE;
    endcase
    state_d = clr_acc ? IDLE : state_d;
    pre_d = (clr_acc || tick) ? '0 : act ? pre_q + PRE_W'(1) : pre_q;
    cnt_reset_d = clr_acc;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q <= '0;
      prev_q <= 3'b111;
      cnt_reset_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      prev_q <= prev_d;
      cnt_reset_q <= cnt_reset_d;
    end
  end
  assign bus.cnt_enable = term ? 4'b0000 :
    {tick & nine[0] & nine[1] & nine[2], tick & nine[0] & nine[1], tick & nine[0], tick};
  assign bus.cnt_reset = cnt_reset_q;
  assign bus.hold = (state_q == LAP);
  assign bus.running = act;
  assign bus.overflow = (state_q == DONE);
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of sequencing, prescaler and carry chain with a 4-cycle tick
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  stopwatch_ctrl_if sw();
  stopwatch_ctrl #(.TICK_DIV(4), .PRE_W(2)) dut (.clock(clk), .reset(rst), .bus(sw));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick_win(input logic [15:0] d, input logic [3:0] exp);
    sw.digits = 16'h0000;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("en_idle_gap", 16'(sw.cnt_enable), 16'h0);
      cyc();
    end
    sw.digits = d;
    #1;
    chk("en_tick", 16'(sw.cnt_enable), 16'(exp));
    chk("run_at_tick", 16'(sw.running), 16'h1);
    cyc();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    sw.btn_start = 1'b1;
    sw.btn_lap = 1'b0;
    sw.btn_clear = 1'b0;
    sw.digits = 16'h0000;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_cnt_reset", 16'(sw.cnt_reset), 16'h1);
    chk("rst_running", 16'(sw.running), 16'h0);
    chk("rst_hold", 16'(sw.hold), 16'h0);
    chk("rst_overflow", 16'(sw.overflow), 16'h0);
    chk("rst_enable", 16'(sw.cnt_enable), 16'h0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("held_cnt_reset", 16'(sw.cnt_reset), 16'h0);
      chk("held_running", 16'(sw.running), 16'h0);
    end
    sw.btn_start = 1'b0;
    cyc();
    sw.btn_start = 1'b1;
    #1;
    chk("press_running_before", 16'(sw.running), 16'h0);
    cyc();
    chk("press_running_after", 16'(sw.running), 16'h1);
    sw.btn_start = 1'b0;
    tick_win(16'h0000, 4'b0001);
    tick_win(16'h0009, 4'b0011);
    tick_win(16'h0999, 4'b1111);
    tick_win(16'h0123, 4'b0001);
    sw.digits = 16'h0000;
    sw.btn_lap = 1'b1;
    #1;
    chk("lap_hold_before", 16'(sw.hold), 16'h0);
    cyc();
    sw.btn_lap = 1'b0;
    chk("lap_hold", 16'(sw.hold), 16'h1);
    chk("lap_en_pre1", 16'(sw.cnt_enable), 16'h0);
    cyc();
    chk("lap_en_pre2", 16'(sw.cnt_enable), 16'h0);
    cyc();
    chk("lap_tick", 16'(sw.cnt_enable), 16'h1);
    chk("lap_running", 16'(sw.running), 16'h1);
    cyc();
    sw.btn_lap = 1'b1;
    cyc();
    sw.btn_lap = 1'b0;
    chk("lap2_hold", 16'(sw.hold), 16'h0);
    chk("lap2_running", 16'(sw.running), 16'h1);
    cyc();
    sw.btn_start = 1'b1;
    #1;
    chk("stop_en_pre2", 16'(sw.cnt_enable), 16'h0);
    cyc();
    sw.btn_start = 1'b0;
    chk("stop_running", 16'(sw.running), 16'h0);
    for (int i = 0; i < 20; i++) begin
      chk("stopped_en", 16'(sw.cnt_enable), 16'h0);
      cyc();
    end
    sw.btn_start = 1'b1;
    cyc();
    sw.btn_start = 1'b0;
    chk("resume_running", 16'(sw.running), 16'h1);
    chk("resume_first_tick", 16'(sw.cnt_enable), 16'h1);
    cyc();
    tick_win(16'h0000, 4'b0001);
    sw.btn_clear = 1'b1;
    cyc();
    sw.btn_clear = 1'b0;
    chk("run_clear_no_reset", 16'(sw.cnt_reset), 16'h0);
    chk("run_clear_running", 16'(sw.running), 16'h1);
    chk("run_clear_pre1", 16'(sw.cnt_enable), 16'h0);
    cyc();
    chk("run_clear_pre2", 16'(sw.cnt_enable), 16'h0);
    cyc();
    chk("run_clear_tick", 16'(sw.cnt_enable), 16'h1);
    cyc();
    tick_win(16'h9999, 4'b0000);
    chk("ovf_overflow", 16'(sw.overflow), 16'h1);
    chk("ovf_running", 16'(sw.running), 16'h0);
    sw.btn_start = 1'b1;
    sw.btn_lap = 1'b1;
    cyc();
    sw.btn_start = 1'b0;
    sw.btn_lap = 1'b0;
    chk("done_ignore_overflow", 16'(sw.overflow), 16'h1);
    chk("done_ignore_running", 16'(sw.running), 16'h0);
    chk("done_ignore_hold", 16'(sw.hold), 16'h0);
    cyc();
    sw.btn_clear = 1'b1;
    #1;
    chk("done_clear_before", 16'(sw.cnt_reset), 16'h0);
    cyc();
    sw.btn_clear = 1'b0;
    sw.digits = 16'h0000;
    chk("done_clear_pulse", 16'(sw.cnt_reset), 16'h1);
    chk("done_clear_overflow", 16'(sw.overflow), 16'h0);
    chk("done_clear_running", 16'(sw.running), 16'h0);
    chk("done_clear_en", 16'(sw.cnt_enable), 16'h0);
    cyc();
    chk("done_clear_pulse_end", 16'(sw.cnt_reset), 16'h0);
    sw.btn_start = 1'b1;
    cyc();
    sw.btn_start = 1'b0;
    chk("restart_running", 16'(sw.running), 16'h1);
    cyc();
    sw.btn_start = 1'b1;
    cyc();
    sw.btn_start = 1'b0;
    chk("stopped_again", 16'(sw.running), 16'h0);
    cyc();
    sw.btn_clear = 1'b1;
    sw.btn_start = 1'b1;
    cyc();
    sw.btn_clear = 1'b0;
    sw.btn_start = 1'b0;
    chk("both_pulse", 16'(sw.cnt_reset), 16'h1);
    chk("both_running", 16'(sw.running), 16'h0);
    cyc();
    chk("both_pulse_end", 16'(sw.cnt_reset), 16'h0);
    chk("both_idle", 16'(sw.running), 16'h0);
    sw.btn_start = 1'b1;
    cyc();
    sw.btn_start = 1'b0;
    chk("midrun_running", 16'(sw.running), 16'h1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrun_rst_running", 16'(sw.running), 16'h0);
    chk("midrun_rst_cnt_reset", 16'(sw.cnt_reset), 16'h1);
    cyc();
    chk("midrun_rst_release", 16'(sw.cnt_reset), 16'h0);
    chk("midrun_rst_idle", 16'(sw.running), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
